// File: rtl/game_flow_controller.sv
// Doodle Jump game sequencer: button debounce, IDLE/PLAY/PAUSE/OVER control,
// vSync-locked movement ticks and a saturating 4-digit BCD score.
module game_flow_controller #(
    parameter logic [19:0] DB_MAX   = 20'd1_000_000,
    parameter int unsigned TICK_DIV = 2
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        vSync,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        fell,
    input  logic        score_inc,
    output logic        move_en,
    output logic        char_rst,
    output logic [1:0]  state,
    output logic [15:0] score_bcd
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_t      cur_state, nxt_state;
    logic        vs_s1, vs_s2, vs_s3, frame_start;
    logic [1:0]  btn_raw, btn_s1, btn_s2, db_level, armed, press;
    logic [1:0]  sync_warm;
    logic [19:0] db_cnt [2];
    logic [7:0]  frame_cnt;
    logic [15:0] bcd_plus1;
    logic        carry;

    assign btn_raw = {btn_pause, btn_start};
    assign state   = cur_state;

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            vs_s1       <= 1'b1;
            vs_s2       <= 1'b1;
            vs_s3       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vs_s1       <= vSync;
            vs_s2       <= vs_s1;
            vs_s3       <= vs_s2;
            frame_start <= vs_s3 & ~vs_s2;
        end
    end

    // A button only arms once it has been seen released after reset, so a
    // press held through reset needs a release before it can count.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            db_level  <= '0;
            armed     <= '0;
            press     <= '0;
            sync_warm <= '0;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            btn_s1    <= btn_raw;
            btn_s2    <= btn_s1;
            sync_warm <= {sync_warm[0], 1'b1};
            for (int unsigned i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (btn_s2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX - 20'd1) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= ~db_level[i];
                    press[i]    <= ~db_level[i] & armed[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
                if (sync_warm[1] && !db_level[i] && !btn_s2[i]) armed[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            cur_state <= IDLE;
            char_rst  <= 1'b1;
        end else begin
            cur_state <= nxt_state;
            char_rst  <= (nxt_state == IDLE);
        end
    end

    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            IDLE:  if (press[0]) nxt_state = PLAY;
            PLAY: begin
                if (fell)          nxt_state = OVER;
                else if (press[1]) nxt_state = PAUSE;
            end
            PAUSE: if (press[1]) nxt_state = PLAY;
            OVER:  if (press[0]) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        bcd_plus1 = score_bcd;
        carry     = 1'b1;
        for (int unsigned d = 0; d < 4; d++) begin
            if (carry) begin
                if (score_bcd[4*d +: 4] == 4'd9) begin
                    bcd_plus1[4*d +: 4] = 4'd0;
                end else begin
                    bcd_plus1[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            score_bcd <= '0;
            move_en   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            move_en <= 1'b0;
            if (cur_state == IDLE && nxt_state == PLAY)
                score_bcd <= '0;
            else if (cur_state == PLAY && score_inc && score_bcd != 16'h9999)
                score_bcd <= bcd_plus1;

            case (cur_state)
                PLAY: begin
                    if (frame_start) begin
                        if (frame_cnt == TICK_LAST) begin
                            frame_cnt <= '0;
                            move_en   <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                PAUSE:   frame_cnt <= frame_cnt;
                default: frame_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: randomized frame/score/button
// timing checked against an event-level model of the game rules.
module tb_game_flow_controller;

    localparam logic [19:0] DB_MAX   = 20'd4;
    localparam int          DB_CYC   = 4;
    localparam int          TICK_DIV = 2;
    localparam int          PRESS_LAT = 2 + DB_CYC + 1;
    localparam int          MOVE_LAT  = 4;

    logic        ClkPort = 1'b0;
    logic        Reset = 1'b1;
    logic        vSync = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_pause = 1'b0;
    logic        fell = 1'b0;
    logic        score_inc = 1'b0;
    logic        move_en, char_rst;
    logic [1:0]  state;
    logic [15:0] score_bcd;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int trans = 0;
    logic [1:0] prev_state;
    int me_q[$];

    logic [1:0] exp_state = 2'b00;
    int exp_score = 0;
    int play_frames = 0;

    game_flow_controller #(.DB_MAX(DB_MAX), .TICK_DIV(TICK_DIV)) dut (
        .ClkPort(ClkPort), .Reset(Reset), .vSync(vSync),
        .btn_start(btn_start), .btn_pause(btn_pause),
        .fell(fell), .score_inc(score_inc),
        .move_en(move_en), .char_rst(char_rst),
        .state(state), .score_bcd(score_bcd)
    );

    always #5 ClkPort = ~ClkPort;
    always @(posedge ClkPort) cyc <= cyc + 1;
    always @(negedge ClkPort) begin
        if (move_en === 1'b1) me_q.push_back(cyc);
        if (state !== prev_state) trans <= trans + 1;
        prev_state <= state;
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge ClkPort);
            #1;
        end
    endtask

    task automatic set_exp(input logic [1:0] s);
        if (exp_state == 2'b00 && s == 2'b01) exp_score = 0;
        if (s == 2'b00 || s == 2'b11) play_frames = 0;
        exp_state = s;
    endtask

    task automatic drive_btn(input int which, input logic v);
        if (which == 0) btn_start = v;
        else            btn_pause = v;
    endtask

    // Hold a button, release it, and report how many cycles until state==want.
    task automatic tap(input int which, input int hold, input logic [1:0] want, output int lat);
        lat = -1;
        drive_btn(which, 1'b1);
        for (int n = 1; n <= hold + 12; n++) begin
            step();
            if (n == hold) drive_btn(which, 1'b0);
            if (lat < 0 && state === want) lat = n;
        end
    endtask

    task automatic pulse_score(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            score_inc = 1'b1;
            step();
            if (gaps) begin
                score_inc = 1'b0;
                step($urandom_range(0, 2));
            end
        end
        score_inc = 1'b0;
        step();
        if (exp_state == 2'b01) exp_score = (exp_score + n > 9999) ? 9999 : exp_score + n;
    endtask

    task automatic run_frames(input int n, input string tag);
        int exp_q[$];
        int fc;
        me_q.delete();
        for (int i = 0; i < n; i++) begin
            vSync = 1'b0;
            fc = cyc;
            step($urandom_range(2, 5));
            vSync = 1'b1;
            step($urandom_range(4, 9));
            if (exp_state == 2'b01) begin
                play_frames++;
                if (play_frames % TICK_DIV == 0) exp_q.push_back(fc + MOVE_LAT);
            end
        end
        step(6);
        n_total++;
        if (me_q.size() != exp_q.size())
            $display("FAIL %s_tick_count: got %0d want %0d", tag, me_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < me_q.size(); i++) begin
            n_total++;
            if (me_q[i] != exp_q[i])
                $display("FAIL %s_tick_time[%0d]: got cycle %0d want %0d", tag, i, me_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic chk_state(input string name);
        n_total++;
        if (state !== exp_state) $display("FAIL %s: state got %b want %b", name, state, exp_state);
        else n_pass++;
    endtask

    task automatic chk_score(input string name);
        n_total++;
        if (score_bcd !== to_bcd(exp_score))
            $display("FAIL %s: score got %h want %h", name, score_bcd, to_bcd(exp_score));
        else n_pass++;
    endtask

    task automatic chk_lat(input string name, input int lat);
        n_total++;
        if (lat != PRESS_LAT) $display("FAIL %s: latency got %0d want %0d", name, lat, PRESS_LAT);
        else n_pass++;
    endtask

    task automatic chk_charrst(input string name, input logic want);
        n_total++;
        if (char_rst !== want) $display("FAIL %s: char_rst got %b want %b", name, char_rst, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(2);
        exp_state = 2'b00;
        exp_score = 0;
        play_frames = 0;
        chk_state("reset_state");
        chk_charrst("reset_char_rst", 1'b1);
        chk_score("reset_score");
        n_total++;
        if (move_en !== 1'b0) $display("FAIL reset_move_en: got %b want 0", move_en);
        else n_pass++;
        Reset = 1'b0;
        run_frames(5, "idle");
        chk_state("idle_after_frames");
    endtask

    task automatic test_start_tick();
        int lat;
        tap(0, 6, 2'b01, lat);
        chk_lat("start_latency", lat);
        set_exp(2'b01);
        chk_state("start_state");
        chk_charrst("play_char_rst", 1'b0);
        run_frames(6, "play");
    endtask

    task automatic test_debounce_glitch();
        int lat, t0, g;
        g = $urandom_range(1, DB_CYC - 1);
        btn_pause = 1'b1;
        step(g);
        btn_pause = 1'b0;
        step(12);
        chk_state("glitch_ignored");
        run_frames(1, "pre_pause");
        t0 = trans;
        tap(1, 10, 2'b10, lat);
        chk_lat("pause_latency", lat);
        set_exp(2'b10);
        chk_state("pause_state");
        n_total++;
        if (trans - t0 != 1) $display("FAIL pause_single_transition: got %0d want 1", trans - t0);
        else n_pass++;
        run_frames(3, "paused");
        tap(1, 6, 2'b01, lat);
        chk_lat("resume_latency", lat);
        set_exp(2'b01);
        run_frames(1, "resume");
    endtask

    task automatic test_score();
        pulse_score($urandom_range(0, 150), 1'b1);
        chk_score("score_random");
        pulse_score(199 - exp_score, 1'b0);
        chk_score("score_0199");
        pulse_score(1, 1'b0);
        chk_score("score_carry_0200");
        pulse_score(9999 - exp_score, 1'b0);
        chk_score("score_9999");
        pulse_score(3, 1'b1);
        chk_score("score_saturate");
    endtask

    task automatic test_over_restart();
        int lat;
        fell = 1'b1;
        step();
        fell = 1'b0;
        set_exp(2'b11);
        chk_state("fell_over");
        chk_charrst("over_char_rst", 1'b0);
        pulse_score(2, 1'b0);
        chk_score("over_score_held");
        tap(1, 6, 2'b10, lat);
        chk_state("over_pause_ignored");
        run_frames(2, "over");
        tap(0, 6, 2'b00, lat);
        chk_lat("over_to_idle_latency", lat);
        set_exp(2'b00);
        chk_charrst("idle_char_rst", 1'b1);
        chk_score("idle_score_held");
        tap(0, 6, 2'b01, lat);
        chk_lat("restart_latency", lat);
        set_exp(2'b01);
        chk_score("restart_score_clear");
    endtask

    task automatic test_simultaneous();
        int lat;
        pulse_score($urandom_range(1, 20), 1'b1);
        chk_score("simul_pre_score");
        btn_pause = 1'b1;
        step(PRESS_LAT - 1);
        fell = 1'b1;
        score_inc = 1'b1;
        step();
        fell = 1'b0;
        score_inc = 1'b0;
        exp_score++;
        set_exp(2'b11);
        chk_state("simul_fell_wins");
        chk_score("simul_score_counted");
        step();
        btn_pause = 1'b0;
        step(12);
        chk_state("simul_stays_over");
        tap(0, 6, 2'b00, lat);
        set_exp(2'b00);
        chk_state("simul_to_idle");
        chk_charrst("simul_idle_char_rst", 1'b1);
        tap(0, 6, 2'b01, lat);
        set_exp(2'b01);
        chk_state("simul_replay");
        chk_score("simul_replay_score");
    endtask

    task automatic test_reset_midgame();
        int lat;
        pulse_score(42, 1'b1);
        tap(1, 6, 2'b10, lat);
        set_exp(2'b10);
        chk_state("mid_pause");
        pulse_score(3, 1'b0);
        chk_score("pause_score_dropped");
        fell = 1'b1;
        step();
        fell = 1'b0;
        step();
        tap(0, 6, 2'b01, lat);
        chk_state("pause_ignores_fell_start");
        btn_start = 1'b1;
        step(10);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        exp_state = 2'b00;
        exp_score = 0;
        play_frames = 0;
        chk_state("midreset_state");
        chk_score("midreset_score");
        chk_charrst("midreset_char_rst", 1'b1);
        step(20);
        chk_state("held_through_reset");
        btn_start = 1'b0;
        step(12);
        chk_state("after_release");
        tap(0, 6, 2'b01, lat);
        chk_lat("repress_latency", lat);
        set_exp(2'b01);
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_debounce_glitch();
        test_score();
        test_over_restart();
        test_simultaneous();
        test_reset_midgame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
